// File: rtl/sub_seq_ctrl.sv
// Nibble-serial A - B - bin controller driving one shared external 4-bit subtract slice.
// The borrow between nibbles is carried only through brw_q, so the slice sees no combinational loop.
module sub_seq_ctrl #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned NIB   = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [3:0]       slice_x,
    output logic [3:0]       slice_y,
    output logic             slice_bin,
    input  logic [3:0]       slice_diff,
    input  logic             slice_bout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NIB - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [IdxW-1:0]  idx_q;
    logic [IdxW+1:0]  lsb;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             brw_q;
    logic             bout_q;
    logic             start_ready_q;
    logic             res_valid_q;

    assign lsb = {idx_q, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            diff_q        <= '0;
            brw_q         <= 1'b0;
            bout_q        <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_valid) begin
                        a_q           <= a;
                        b_q           <= b;
                        brw_q         <= bin;
                        idx_q         <= '0;
                        start_ready_q <= 1'b0;
                        state_q       <= StRun;
                    end
                end
                StRun: begin
                    diff_q[lsb +: 4] <= slice_diff;
                    brw_q            <= slice_bout;
                    if (idx_q == IdxLast) begin
                        idx_q       <= '0;
                        bout_q      <= slice_bout;
                        res_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (res_ready) begin
                        res_valid_q   <= 1'b0;
                        start_ready_q <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    start_ready_q <= 1'b1;
                    res_valid_q   <= 1'b0;
                end
            endcase
        end
    end

    // Zero on the slice means idle, since other users share it.
    always_comb begin
        slice_x   = 4'h0;
        slice_y   = 4'h0;
        slice_bin = 1'b0;
        if (state_q == StRun) begin
            slice_x   = a_q[lsb +: 4];
            slice_y   = b_q[lsb +: 4];
            slice_bin = brw_q;
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign diff        = diff_q;
    assign bout        = bout_q;
    assign zero        = (diff_q == '0);

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Randomized bench for sub_seq_ctrl: WIDTH=8 and WIDTH=24 instances, each with a behavioural slice,
// compared against plain-arithmetic subtraction.
module tb_sub_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        sv;
    logic        rr;
    logic        bin_i;
    logic        sel24;
    logic [23:0] a_i;
    logic [23:0] b_i;

    logic        sr8, rv8, bo8, z8, sbin8, sbout8;
    logic [3:0]  sx8, sy8, sd8;
    logic [7:0]  d8;
    logic        sr24, rv24, bo24, z24, sbin24, sbout24;
    logic [3:0]  sx24, sy24, sd24;
    logic [23:0] d24;

    int n_pass = 0;
    int n_checks = 0;

    sub_seq_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_valid(sv & ~sel24), .start_ready(sr8),
        .a(a_i[7:0]), .b(b_i[7:0]), .bin(bin_i),
        .slice_x(sx8), .slice_y(sy8), .slice_bin(sbin8), .slice_diff(sd8), .slice_bout(sbout8),
        .res_valid(rv8), .res_ready(rr & ~sel24), .diff(d8), .bout(bo8), .zero(z8)
    );

    sub_seq_ctrl #(.WIDTH(24)) u_dut24 (
        .clk(clk), .rst(rst), .start_valid(sv & sel24), .start_ready(sr24),
        .a(a_i), .b(b_i), .bin(bin_i),
        .slice_x(sx24), .slice_y(sy24), .slice_bin(sbin24), .slice_diff(sd24),
        .slice_bout(sbout24),
        .res_valid(rv24), .res_ready(rr & sel24), .diff(d24), .bout(bo24), .zero(z24)
    );

    // 4-bit subtract slices: the 5-bit result's top bit is the borrow.
    assign {sbout8, sd8}   = {1'b0, sx8} - {1'b0, sy8} - {4'b0, sbin8};
    assign {sbout24, sd24} = {1'b0, sx24} - {1'b0, sy24} - {4'b0, sbin24};

    logic [23:0] o_diff;
    logic        o_bout, o_zero, o_rv, o_sr, o_sbin;
    logic [3:0]  o_sx, o_sy;
    assign o_diff = sel24 ? d24 : {16'b0, d8};
    assign o_bout = sel24 ? bo24 : bo8;
    assign o_zero = sel24 ? z24 : z8;
    assign o_rv   = sel24 ? rv24 : rv8;
    assign o_sr   = sel24 ? sr24 : sr8;
    assign o_sbin = sel24 ? sbin24 : sbin8;
    assign o_sx   = sel24 ? sx24 : sx8;
    assign o_sy   = sel24 ? sy24 : sy8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer difference, reduced modulo 2^w; negative means a borrow out.
    function automatic logic [24:0] ref_sub(input int w, input logic [23:0] x, input logic [23:0] y,
                                            input logic bn);
        longint t;
        longint m;
        m = longint'(1) << w;
        t = longint'(x) - longint'(y) - longint'(bn);
        return {t < 0, 24'((t + m) % m)};
    endfunction

    task automatic check_idle_reset(input string tag);
        check({tag, ".sr"}, 32'(o_sr), 1);
        check({tag, ".rv"}, 32'(o_rv), 0);
        check({tag, ".diff"}, 32'(o_diff), 0);
        check({tag, ".bout"}, 32'(o_bout), 0);
        check({tag, ".zero"}, 32'(o_zero), 1);
        check({tag, ".slice"}, {23'b0, o_sx, o_sy, o_sbin}, 0);
    endtask

    task automatic run_op(input int w, input logic [23:0] x, input logic [23:0] y, input logic bn,
                          input int hold, input string tag, output logic [7:0] sbl);
        int          nib;
        int          n;
        logic [24:0] exp;
        logic [23:0] mask;
        nib   = w / 4;
        mask  = (w == 24) ? 24'hFFFFFF : 24'h0000FF;
        x     = x & mask;
        y     = y & mask;
        sbl   = '0;
        sel24 = (w == 24);
        a_i   = x;
        b_i   = y;
        bin_i = bn;
        rr    = 1'b0;
        #1;
        check({tag, ".ready"}, 32'(o_sr), 1);
        sv = 1'b1;
        tick();
        sv = 1'b0;
        n  = 1;
        while (!o_rv && n < 40) begin
            if (n - 1 < nib) begin
                check({tag, ".sx"}, 32'(o_sx), 32'((x >> (4 * (n - 1))) & 24'hF));
                check({tag, ".sy"}, 32'(o_sy), 32'((y >> (4 * (n - 1))) & 24'hF));
                check({tag, ".sr_run"}, 32'(o_sr), 0);
                sbl[n-1] = o_sbin;
            end
            // Operands changing after accept must not reach the slice.
            a_i   = 24'($urandom);
            b_i   = 24'($urandom);
            bin_i = 1'($urandom);
            tick();
            n++;
        end
        exp = ref_sub(w, x, y, bn);
        check({tag, ".latency"}, 32'(n), 32'(nib + 1));
        check({tag, ".diff"}, 32'(o_diff), 32'(exp[23:0]));
        check({tag, ".bout"}, 32'(o_bout), 32'(exp[24]));
        check({tag, ".zero"}, 32'(o_zero), 32'(exp[23:0] == 0));
        check({tag, ".slice_done"}, {23'b0, o_sx, o_sy, o_sbin}, 0);
        check({tag, ".sr_done"}, 32'(o_sr), 0);
        for (int i = 0; i < hold; i++) begin
            sv = 1'($urandom);
            tick();
            check({tag, ".hold_rv"}, 32'(o_rv), 1);
            check({tag, ".hold_diff"}, 32'(o_diff), 32'(exp[23:0]));
            check({tag, ".hold_bout"}, 32'(o_bout), 32'(exp[24]));
            check({tag, ".hold_sr"}, 32'(o_sr), 0);
        end
        sv = 1'b0;
        rr = 1'b1;
        tick();
        rr = 1'b0;
        check({tag, ".rv_drop"}, 32'(o_rv), 0);
        check({tag, ".sr_back"}, 32'(o_sr), 1);
        check({tag, ".idle_diff"}, 32'(o_diff), 32'(exp[23:0]));
        check({tag, ".idle_bout"}, 32'(o_bout), 32'(exp[24]));
        tick();
        check({tag, ".no_restart"}, 32'(o_sr), 1);
    endtask

    initial begin
        logic [7:0] sbl;
        sv = 0; rr = 0; bin_i = 0; sel24 = 0; a_i = '0; b_i = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_idle_reset("rst8");
        sel24 = 1'b1;
        #1;
        check_idle_reset("rst24");

        run_op(8, 24'h35, 24'h12, 1'b0, 0, "w8_35_12", sbl);
        check("w8_35_12.sbin", 32'(sbl[1:0]), 0);
        run_op(8, 24'h12, 24'h35, 1'b0, 0, "w8_12_35", sbl);
        run_op(8, 24'h10, 24'h01, 1'b0, 0, "w8_10_01", sbl);
        check("w8_10_01.sbin", 32'(sbl[1:0]), 32'b10);
        run_op(8, 24'h00, 24'h00, 1'b1, 0, "w8_00_00_b", sbl);
        run_op(8, 24'hA7, 24'hA7, 1'b0, 0, "w8_a7_a7", sbl);
        run_op(24, 24'h800000, 24'h000001, 1'b0, 5, "w24_bp", sbl);

        // Abandon an operation at idx=1.
        sel24 = 1'b1;
        a_i = 24'h123456; b_i = 24'h000111; bin_i = 1'b0;
        sv = 1'b1;
        tick();
        sv = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_idle_reset("midrun");
        run_op(24, 24'h00FFFF, 24'hFFFFFF, 1'b1, 1, "w24_after_rst", sbl);

        for (int k = 0; k < 25; k++) begin
            run_op(8, 24'($urandom), 24'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                   $sformatf("r8_%0d", k), sbl);
            run_op(24, 24'($urandom), 24'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                   $sformatf("r24_%0d", k), sbl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
